// File: rtl/word_select_gen_if.sv
// Instruction handshake between the word source and word_select_gen.
// The source offers is_word/is_valid; the generator raises is_ready at the last bit time.
interface word_select_gen_if #(
  parameter int unsigned IS_BITS = 10
);
  logic [IS_BITS-1:0] is_word;
  logic               is_valid;
  logic               is_ready;

  modport master (
    output is_word,
    output is_valid,
    input  is_ready
  );

  modport slave (
    input  is_word,
    input  is_valid,
    output is_ready
  );
endinterface

// File: rtl/word_select_gen.sv
// Word-time generator for ARC: bit/digit counter, serial instruction with sync,
// field-decoded word select and a loadable digit pointer, all on cph2.
module word_select_gen #(
  parameter int unsigned DIGITS     = 14,
  parameter int unsigned BPD        = 4,
  parameter int unsigned EXP_DIGITS = 3,
  parameter int unsigned IS_BITS    = 10,
  parameter int unsigned SYNC_START = 45,
  parameter int unsigned PTR_RESET  = 3,
  parameter bit          GATE_WS    = 1'b0,
  localparam int unsigned F  = DIGITS * BPD,
  localparam int unsigned DW = $clog2(DIGITS),
  localparam int unsigned CW = $clog2(F)
) (
  input  logic                cph2,
  input  logic                rst,
  word_select_gen_if.slave    is_bus,
  input  logic [1:0]          ptr_cmd,
  input  logic [DW-1:0]       ptr_din,
  output logic                sync,
  output logic                is,
  output logic                ws,
  output logic [CW-1:0]       cnt,
  output logic [DW-1:0]       digit,
  output logic [DW-1:0]       ptr,
  output logic [7:0]          adr,
  output logic                frame_start
);

  localparam int unsigned IW = (IS_BITS > 1) ? $clog2(IS_BITS) : 1;

  if (SYNC_START + IS_BITS > F) begin : g_cfg_err
    $error("word_select_gen: instruction window runs past the end of the frame");
  end

  typedef enum logic [1:0] {
    PtrNone = 2'b00,
    PtrSet  = 2'b01,
    PtrInc  = 2'b10,
    PtrDec  = 2'b11
  } ptr_cmd_e;

  typedef enum logic [2:0] {
    FldP  = 3'b000,
    FldM  = 3'b001,
    FldX  = 3'b010,
    FldW  = 3'b011,
    FldWp = 3'b100,
    FldMs = 3'b101,
    FldXs = 3'b110,
    FldS  = 3'b111
  } fld_e;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         adr_q, adr_d;
  logic [DW-1:0]      ptr_q, ptr_d;
  logic [IS_BITS-1:0] cur_word_q, cur_word_d;
  fld_e               fld_q, fld_d;
  logic               en_q, en_d;

  logic               wrap;
  logic [IW-1:0]      is_idx;
  logic               ws_raw;

  assign wrap = (cnt_q == CW'(F - 1));

  // Everything frame-level commits on the wrap edge, so a new ptr and a new
  // field become visible together at digit 0 of the next frame.
  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    adr_d      = adr_q;
    ptr_d      = ptr_q;
    cur_word_d = cur_word_q;
    fld_d      = fld_q;
    en_d       = en_q;
    if (wrap) begin
      adr_d      = adr_q + 8'd1;
      cur_word_d = is_bus.is_valid ? is_bus.is_word : '0;
      fld_d      = fld_e'(cur_word_q[4:2]);
      en_d       = (cur_word_q[1:0] == 2'b10);
      unique case (ptr_cmd_e'(ptr_cmd))
        PtrNone: ptr_d = ptr_q;
        PtrSet:  ptr_d = (ptr_din > DW'(DIGITS - 1)) ? DW'(DIGITS - 1) : ptr_din;
        PtrInc:  ptr_d = (ptr_q == DW'(DIGITS - 1)) ? '0 : ptr_q + 1'b1;
        PtrDec:  ptr_d = (ptr_q == '0) ? DW'(DIGITS - 1) : ptr_q - 1'b1;
        default: ptr_d = ptr_q;
      endcase
    end
  end

  always_ff @(posedge cph2 or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      adr_q      <= '0;
      ptr_q      <= DW'(PTR_RESET);
      cur_word_q <= '0;
      fld_q      <= FldP;
      en_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      ptr_q      <= ptr_d;
      cur_word_q <= cur_word_d;
      fld_q      <= fld_d;
      en_q       <= en_d;
    end
  end

  assign cnt         = cnt_q;
  assign adr         = adr_q;
  assign ptr         = ptr_q;
  assign digit       = DW'(cnt_q / CW'(BPD));
  assign frame_start = (cnt_q == '0);
  assign is_bus.is_ready = wrap;

  assign sync   = (cnt_q >= CW'(SYNC_START)) && (cnt_q <= CW'(SYNC_START + IS_BITS - 1));
  assign is_idx = IW'(cnt_q - CW'(SYNC_START));
  assign is     = sync & cur_word_q[is_idx];

  always_comb begin
    ws_raw = 1'b0;
    unique case (fld_q)
      FldP:    ws_raw = (digit == ptr_q);
      FldM:    ws_raw = (digit >= DW'(EXP_DIGITS)) && (digit <= DW'(DIGITS - 2));
      FldX:    ws_raw = (digit < DW'(EXP_DIGITS));
      FldW:    ws_raw = 1'b1;
      FldWp:   ws_raw = (digit <= ptr_q);
      FldMs:   ws_raw = (digit >= DW'(EXP_DIGITS)) && (digit <= DW'(DIGITS - 1));
      FldXs:   ws_raw = (digit == DW'(EXP_DIGITS - 1));
      FldS:    ws_raw = (digit == DW'(DIGITS - 1));
      default: ws_raw = 1'b0;
    endcase
  end

  assign ws = ws_raw & (en_q | ~GATE_WS);

endmodule

// File: tb/tb_word_select_gen.sv
// Directed bench for word_select_gen: an ungated and a gated instance share clock
// and reset; expected values are hand-derived constants and bit-range masks.
module tb_word_select_gen;

  localparam int unsigned F  = 56;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 6;

  logic cph2;
  logic rst;

  word_select_gen_if #(.IS_BITS(10)) bus ();
  word_select_gen_if #(.IS_BITS(10)) bus_g ();

  logic [1:0]    ptr_cmd, ptr_cmd_g;
  logic [DW-1:0] ptr_din, ptr_din_g;
  logic          sync, is, ws, frame_start;
  logic [CW-1:0] cnt;
  logic [DW-1:0] digit, ptr;
  logic [7:0]    adr;
  logic          sync_g, is_g, ws_g, frame_start_g;
  logic [CW-1:0] cnt_g;
  logic [DW-1:0] digit_g, ptr_g;
  logic [7:0]    adr_g;

  word_select_gen dut (
    .cph2        (cph2),
    .rst         (rst),
    .is_bus      (bus),
    .ptr_cmd     (ptr_cmd),
    .ptr_din     (ptr_din),
    .sync        (sync),
    .is          (is),
    .ws          (ws),
    .cnt         (cnt),
    .digit       (digit),
    .ptr         (ptr),
    .adr         (adr),
    .frame_start (frame_start)
  );

  word_select_gen #(.GATE_WS(1'b1)) dut_g (
    .cph2        (cph2),
    .rst         (rst),
    .is_bus      (bus_g),
    .ptr_cmd     (ptr_cmd_g),
    .ptr_din     (ptr_din_g),
    .sync        (sync_g),
    .is          (is_g),
    .ws          (ws_g),
    .cnt         (cnt_g),
    .digit       (digit_g),
    .ptr         (ptr_g),
    .adr         (adr_g),
    .frame_start (frame_start_g)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial cph2 = 1'b0;
  always #5 cph2 = ~cph2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cph2);
    #1;
  endtask

  task automatic goto_cnt(input int v);
    int k = 0;
    while (cnt != CW'(v) && k < 2 * F) begin
      step();
      k++;
    end
    if (cnt != CW'(v)) check_eq("goto_cnt", 64'(cnt), 64'(v));
  endtask

  function automatic logic [55:0] rng(input int lo, input int hi);
    logic [55:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drive_word(input logic [9:0] w, input logic v);
    bus.is_word   = w;
    bus.is_valid  = v;
    bus_g.is_word  = w;
    bus_g.is_valid = v;
  endtask

  // Starts at cnt 0, samples ws of both instances across one frame, ends at next cnt 0.
  task automatic collect_frame(output logic [55:0] m, output logic [55:0] mg);
    goto_cnt(0);
    m  = '0;
    mg = '0;
    for (int i = 0; i < F; i++) begin
      m[i]  = ws;
      mg[i] = ws_g;
      step();
    end
  endtask

  task automatic ptr_op(input logic [1:0] cmd, input logic [DW-1:0] din);
    goto_cnt(55);
    ptr_cmd = cmd;
    ptr_din = din;
    step();
    ptr_cmd = 2'b00;
  endtask

  // Word accepted at one wrap; its field drives ws in the frame after next.
  task automatic run_field(input logic [9:0] w, output logic [55:0] m, output logic [55:0] mg);
    goto_cnt(55);
    drive_word(w, 1'b1);
    step();
    drive_word('0, 1'b0);
    goto_cnt(55);
    step();
    collect_frame(m, mg);
  endtask

  logic [55:0] m, mg;
  logic [9:0]  bits;
  int          k, nsync;

  initial begin
    rst       = 1'b1;
    ptr_cmd   = 2'b00;
    ptr_din   = '0;
    ptr_cmd_g = 2'b00;
    ptr_din_g = '0;
    drive_word('0, 1'b0);
    step(); step(); step();

    check_eq("rst_cnt", 64'(cnt), 64'd0);
    check_eq("rst_adr", 64'(adr), 64'd0);
    check_eq("rst_ptr", 64'(ptr), 64'd3);
    check_eq("rst_out", 64'({sync, is, frame_start, bus.is_ready, ws, ws_g}), 64'b001000);

    rst = 1'b0;
    step();
    check_eq("first_cnt", 64'(cnt), 64'd1);

    // Reset held mid-frame
    goto_cnt(20);
    rst = 1'b1;
    #1;
    check_eq("async_rst_cnt", 64'(cnt), 64'd0);
    step(); step(); step();
    check_eq("mid_rst_state", 64'({cnt, adr, ptr}), 64'({6'd0, 8'd0, 4'd3}));
    check_eq("mid_rst_out", 64'({sync, is, frame_start, bus.is_ready}), 64'b0010);
    rst = 1'b0;
    k = 0;
    while (!sync && k < 100) begin
      step();
      k++;
    end
    check_eq("sync_delay", 64'(k), 64'd45);

    // Serialisation
    check_eq("ready_low", 64'(bus.is_ready), 64'd0);
    drive_word(10'b11101_010_00, 1'b1);
    goto_cnt(55);
    check_eq("ready_high", 64'(bus.is_ready), 64'd1);
    step();
    drive_word('0, 1'b0);
    check_eq("adr_after_wrap", 64'(adr), 64'd1);
    check_eq("frame_start", 64'(frame_start), 64'd1);
    goto_cnt(44);
    check_eq("sync_pre", 64'(sync), 64'd0);
    step();
    nsync = 0;
    for (int i = 0; i < 10; i++) begin
      bits[i] = is;
      if (sync) nsync++;
      step();
    end
    check_eq("is_bits", 64'(bits), 64'h3a8);
    check_eq("sync_len", 64'(nsync), 64'd10);
    check_eq("sync_post", 64'(sync), 64'd0);
    step();

    collect_frame(m, mg);
    check_eq("ws_field_x", 64'(m), 64'(rng(0, 11)));
    collect_frame(m, mg);
    check_eq("ws_field_p3", 64'(m), 64'(rng(12, 15)));

    // Pointer: commands away from the wrap are ignored
    ptr_cmd = 2'b10;
    goto_cnt(55);
    check_eq("ptr_ignored", 64'(ptr), 64'd3);
    ptr_cmd = 2'b01;
    ptr_din = 4'd13;
    step();
    ptr_cmd = 2'b00;
    check_eq("ptr_set13", 64'(ptr), 64'd13);
    ptr_op(2'b10, '0);
    check_eq("ptr_inc_wrap", 64'(ptr), 64'd0);
    ptr_op(2'b11, '0);
    check_eq("ptr_dec_wrap", 64'(ptr), 64'd13);
    ptr_op(2'b01, 4'd15);
    check_eq("ptr_clamp", 64'(ptr), 64'd13);
    ptr_op(2'b11, '0);
    check_eq("ptr_dec", 64'(ptr), 64'd12);
    ptr_op(2'b01, 4'd5);
    check_eq("ptr_set5", 64'(ptr), 64'd5);

    // Fields with P=5
    run_field(10'b00000_000_00, m, mg);
    check_eq("ws_p5", 64'(m), 64'(rng(20, 23)));
    run_field(10'b00000_001_00, m, mg);
    check_eq("ws_m", 64'(m), 64'(rng(12, 51)));
    run_field(10'b00000_100_00, m, mg);
    check_eq("ws_wp", 64'(m), 64'(rng(0, 23)));
    run_field(10'b00000_101_00, m, mg);
    check_eq("ws_ms", 64'(m), 64'(rng(12, 55)));
    run_field(10'b00000_110_00, m, mg);
    check_eq("ws_xs", 64'(m), 64'(rng(8, 11)));
    run_field(10'b00000_111_00, m, mg);
    check_eq("ws_s", 64'(m), 64'(rng(52, 55)));

    // Gating on class bits
    run_field(10'b00000_011_10, m, mg);
    check_eq("ws_w_ungated", 64'(m), 64'(rng(0, 55)));
    check_eq("ws_w_gated_cls10", 64'(mg), 64'(rng(0, 55)));
    run_field(10'b00000_011_00, m, mg);
    check_eq("ws_w_ungated_cls00", 64'(m), 64'(rng(0, 55)));
    check_eq("ws_w_gated_cls00", 64'(mg), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
